// File: rtl/cv32e40x_pkg.sv
// Shared types for the Zbc carry-less multiply sequencer.
// Optional macro: CV32E40X_CLMUL_EARLY_TERM_EN (used in cv32e40x_b_clmul_seq).
package cv32e40x_pkg;

    typedef enum logic [1:0] {
        CLMUL_OP  = 2'b00,
        CLMULH_OP = 2'b01,
        CLMULR_OP = 2'b10
    } clmul_op_e;

    typedef enum logic [1:0] {
        CLMUL_IDLE,
        CLMUL_BUSY,
        CLMUL_DONE
    } clmul_state_e;

    localparam int CLMUL_MAX_BPC = 8;

    // The reserved encoding 2'b11 falls through to the low half, like CLMUL.
    function automatic logic [31:0] clmul_select(
        input clmul_op_e   op,
        input logic [63:0] p
    );
        logic [31:0] r;
        case (op)
            CLMULH_OP: r = p[63:32];
            CLMULR_OP: r = p[62:31];
            default:   r = p[31:0];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cv32e40x_b_clmul_step.sv
// One combinational shift/XOR step of the carry-less multiply.
// Optional macro: none.
module cv32e40x_b_clmul_step #(
    parameter int BPC = 4
) (
    input  logic [63:0]    acc_i,
    input  logic [31:0]    a_i,
    input  logic [BPC-1:0] b_bits_i,
    input  logic [5:0]     shamt_i,
    output logic [63:0]    acc_o
);

    always_comb begin
        acc_o = acc_i;
        for (int i = 0; i < BPC; i++) begin
            if (b_bits_i[i]) begin
                acc_o = acc_o ^ ({32'b0, a_i} << (shamt_i + 6'(i)));
            end
        end
    end

endmodule

// File: rtl/cv32e40x_b_clmul_seq.sv
// Multi-cycle sequencer for clmul/clmulh/clmulr.
// Optional macro: CV32E40X_CLMUL_EARLY_TERM_EN (exit BUSY once op_b is exhausted).
module cv32e40x_b_clmul_seq
    import cv32e40x_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [1:0]  operator_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic        kill_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] result_o
);

    localparam int NCYC  = 32 / BITS_PER_CYCLE;
    localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCYC - 1);

    if (!((BITS_PER_CYCLE == 1) || (BITS_PER_CYCLE == 2) ||
          (BITS_PER_CYCLE == 4) || (BITS_PER_CYCLE == 8)) ||
        (BITS_PER_CYCLE > CLMUL_MAX_BPC)) begin : g_bpc_chk
        $error("BITS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    clmul_state_e state_q, state_d;
    clmul_op_e    op_q, op_d;
    logic [31:0]  a_q, a_d;
    logic [31:0]  b_q, b_d;
    logic [63:0]  acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]  result_q, result_d;
    logic         valid_q, valid_d;
    logic         ready_q, ready_d;

    logic [63:0]  acc_step;
    logic [31:0]  b_shift;
    logic [5:0]   shamt;
    logic         last;

    assign shamt   = 6'(cnt_q) * 6'(BITS_PER_CYCLE);
    assign b_shift = b_q >> BITS_PER_CYCLE;

    cv32e40x_b_clmul_step #(
        .BPC (BITS_PER_CYCLE)
    ) u_step (
        .acc_i    (acc_q),
        .a_i      (a_q),
        .b_bits_i (b_q[BITS_PER_CYCLE-1:0]),
        .shamt_i  (shamt),
        .acc_o    (acc_step)
    );

`ifdef CV32E40X_CLMUL_EARLY_TERM_EN
    assign last = (cnt_q == CNT_LAST) || (b_shift == 32'b0);
`else
    assign last = (cnt_q == CNT_LAST);
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        valid_d  = valid_q;
        ready_d  = ready_q;

        unique case (state_q)
            CLMUL_IDLE: begin
                if (valid_i && ready_q) begin
                    state_d = CLMUL_BUSY;
                    op_d    = clmul_op_e'(operator_i);
                    a_d     = op_a_i;
                    b_d     = op_b_i;
                    acc_d   = 64'b0;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                end
            end
            CLMUL_BUSY: begin
                acc_d = acc_step;
                b_d   = b_shift;
                cnt_d = cnt_q + CNT_W'(1);
                if (last) begin
                    state_d  = CLMUL_DONE;
                    valid_d  = 1'b1;
                    result_d = clmul_select(op_q, acc_step);
                end
            end
            CLMUL_DONE: begin
                // ready_o only rises after the handoff edge, never alongside it.
                if (ready_i) begin
                    state_d = CLMUL_IDLE;
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = CLMUL_IDLE;
                valid_d = 1'b0;
                ready_d = 1'b1;
            end
        endcase

        if (kill_i) begin
            state_d = CLMUL_IDLE;
            valid_d = 1'b0;
            ready_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= CLMUL_IDLE;
            op_q     <= CLMUL_OP;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
        end
    end

    assign ready_o  = ready_q;
    assign valid_o  = valid_q;
    assign result_o = result_q;

endmodule
